// File: rtl/dmux8way_dispatcher_pkg.sv
// Shared constants and FSM encoding for the 8-way demux dispatcher.
package dmux8way_dispatcher_pkg;

   localparam int DISP_DATA_W = 4;
   localparam int DISP_SEL_W  = 3;
   localparam int DISP_NDST   = 8;

   // IDLE: output register empty; HOLD: output register carries a live word.
   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } disp_state_t;

endpackage

// File: rtl/dmux8way_dispatcher_if.sv
// Source-side and demux-side signals of the dispatcher bundled together.
// The slave modport is the dispatcher's view; master is the environment's.
interface dmux8way_dispatcher_if
   import dmux8way_dispatcher_pkg::*;
#(
   parameter int DATA_W = DISP_DATA_W,
   parameter int SEL_W  = DISP_SEL_W,
   parameter int DEPTH  = 4
);

   localparam int NDST  = 2 ** SEL_W;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic [NDST-1:0]   dst_ready;
   logic [DATA_W-1:0] out_data;
   logic [SEL_W-1:0]  out_sel;
   logic              out_valid;
   logic [CNT_W-1:0]  fifo_count;

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready,
      input  dst_ready,
      output out_data,
      output out_sel,
      output out_valid,
      output fifo_count
   );

   modport master (
      output in_data,
      output in_valid,
      input  in_ready,
      output dst_ready,
      input  out_data,
      input  out_sel,
      input  out_valid,
      input  fifo_count
   );

endinterface

// File: rtl/dmux8way_dispatcher_fifo.sv
// Small circular FIFO with show-ahead head word, occupancy count and flags.
// Pointers wrap naturally because DEPTH is a power of two.
module dispatcher_fifo #(
   parameter int W     = 4,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [W-1:0]               wdata,
   input  logic                       pop,
   output logic [W-1:0]               rdata,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [W-1:0]     mem_reg [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count_reg == CNT_W'(DEPTH));
   assign empty   = (count_reg == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rdata   = mem_reg[rd_ptr_reg];
   assign count   = count_reg;

   // Storage array: written on accepted push, no reset needed on data.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_reg[wr_ptr_reg] <= wdata;
      end
   end

   // Pointer and occupancy bookkeeping; reset discards all contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/dmux8way_dispatcher.sv
// Feeds an 8-way demux: buffers incoming words in a FIFO and issues each
// one with a destination select picked round-robin among ready destinations.
module dmux8way_dispatcher
   import dmux8way_dispatcher_pkg::*;
#(
   parameter int DATA_W = DISP_DATA_W,
   parameter int SEL_W  = DISP_SEL_W,
   parameter int DEPTH  = 4
) (
   input logic                 clk,
   input logic                 rst_n,
   dmux8way_dispatcher_if.slave bus
);

   localparam int NDST  = 2 ** SEL_W;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   disp_state_t       state_reg, state_next;
   logic [DATA_W-1:0] out_data_reg, out_data_next;
   logic [SEL_W-1:0]  out_sel_reg, out_sel_next;
   logic [SEL_W-1:0]  rr_reg, rr_next;

   logic [DATA_W-1:0] fifo_rdata;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_full;
   logic              fifo_empty;
   logic              push;
   logic              accept;
   logic              load;

   logic [NDST-1:0]   rot_ready;
   logic [SEL_W-1:0]  grant_off;
   logic [SEL_W-1:0]  grant;
   logic              grant_valid;

   // in_ready depends only on registered occupancy, so a full FIFO never
   // passes a word through even if the head pops on the same edge.
   assign bus.in_ready   = !fifo_full;
   assign push           = bus.in_valid && !fifo_full;
   assign accept         = (state_reg == HOLD) && bus.dst_ready[out_sel_reg];
   assign rr_next        = accept ? out_sel_reg + 1'b1 : rr_reg;
   assign load           = !fifo_empty && ((state_reg == IDLE) || accept) && grant_valid;

   assign bus.out_valid  = (state_reg == HOLD);
   assign bus.out_data   = out_data_reg;
   assign bus.out_sel    = out_sel_reg;
   assign bus.fifo_count = fifo_count;

   dispatcher_fifo #(
      .W     (DATA_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata (bus.in_data),
      .pop   (load),
      .rdata (fifo_rdata),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Rotate dst_ready so that bit 0 is the destination at rr_next.
   generate
      for (genvar gi = 0; gi < NDST; gi++) begin : g_rot
         assign rot_ready[gi] = bus.dst_ready[rr_next + SEL_W'(gi)];
      end
   endgenerate

   // First ready destination at or after rr_next (lowest rotated offset).
   always_comb begin
      grant_valid = 1'b0;
      grant_off   = '0;
      for (int i = NDST - 1; i >= 0; i--) begin
         if (rot_ready[i]) begin
            grant_valid = 1'b1;
            grant_off   = SEL_W'(i);
         end
      end
      grant = rr_next + grant_off;
   end

   // Next state and output register contents.
   always_comb begin
      state_next    = state_reg;
      out_data_next = out_data_reg;
      out_sel_next  = out_sel_reg;
      case (state_reg)
         IDLE: begin
            if (load) begin
               state_next    = HOLD;
               out_data_next = fifo_rdata;
               out_sel_next  = grant;
            end
         end
         HOLD: begin
            if (load) begin
               out_data_next = fifo_rdata;
               out_sel_next  = grant;
            end else if (accept) begin
               state_next    = IDLE;
               out_data_next = '0;
            end
         end
         default: begin
            state_next    = IDLE;
            out_data_next = '0;
         end
      endcase
   end

   // State, output register and round-robin pointer; reset clears at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         out_data_reg <= '0;
         out_sel_reg  <= '0;
         rr_reg       <= '0;
      end else begin
         state_reg    <= state_next;
         out_data_reg <= out_data_next;
         out_sel_reg  <= out_sel_next;
         rr_reg       <= rr_next;
      end
   end

endmodule

// File: tb/tb_dmux8way_dispatcher.sv
// Directed bench for the 8-way demux dispatcher. Inputs change and outputs
// are sampled on the falling edge; the design acts on the rising edge.
module tb_dmux8way_dispatcher;

   logic clk;
   logic rst_n;
   int   tests_run;
   int   tests_failed;

   dmux8way_dispatcher_if #(.DATA_W(4), .SEL_W(3), .DEPTH(4)) bus ();

   dmux8way_dispatcher #(.DATA_W(4), .SEL_W(3), .DEPTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic apply_reset();
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = 4'h0;
      bus.dst_ready = 8'h00;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = 4'h0;
      bus.dst_ready = 8'h00;
      repeat (3) @(negedge clk);
      tests_run++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL reset_held: out_valid=%b in_ready=%b, need 0/1", bus.out_valid, bus.in_ready);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      tests_run++;
      if (bus.out_valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_out_valid: got %b need 0", bus.out_valid);
      end
      tests_run++;
      if (bus.out_data !== 4'h0 || bus.out_sel !== 3'd0) begin
         tests_failed++;
         $display("[TB] FAIL reset_out_data: data=%h sel=%0d need 0/0", bus.out_data, bus.out_sel);
      end
      tests_run++;
      if (bus.in_ready !== 1'b1 || bus.fifo_count !== 3'd0) begin
         tests_failed++;
         $display("[TB] FAIL reset_fifo: in_ready=%b count=%0d need 1/0", bus.in_ready, bus.fifo_count);
      end
      $display("[TB] reset: out_valid=%b in_ready=%b count=%0d", bus.out_valid, bus.in_ready, bus.fifo_count);
   endtask

   // Words 1..9 pushed on consecutive edges with all destinations ready.
   task automatic test_round_robin();
      logic [3:0] exp_d;
      logic [2:0] exp_s;
      apply_reset();
      bus.dst_ready = 8'hFF;
      for (int k = 0; k <= 11; k++) begin
         if (k >= 2 && k <= 10) begin
            exp_d = 4'(k - 1);
            exp_s = 3'((k - 2) % 8);
            tests_run++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d || bus.out_sel !== exp_s) begin
               tests_failed++;
               $display("[TB] FAIL rr_issue k=%0d: valid=%b data=%h sel=%0d need 1/%h/%0d",
                        k, bus.out_valid, bus.out_data, bus.out_sel, exp_d, exp_s);
            end
            $display("[TB] rr issue: data=%h sel=%0d", bus.out_data, bus.out_sel);
         end else begin
            tests_run++;
            if (bus.out_valid !== 1'b0 || bus.out_data !== 4'h0) begin
               tests_failed++;
               $display("[TB] FAIL rr_idle k=%0d: valid=%b data=%h need 0/0", k, bus.out_valid, bus.out_data);
            end
         end
         if (k == 1) begin
            tests_run++;
            if (bus.fifo_count !== 3'd1) begin
               tests_failed++;
               $display("[TB] FAIL rr_count_first: got %0d need 1", bus.fifo_count);
            end
         end
         if (k <= 8) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 4'(k + 1);
         end else begin
            bus.in_valid = 1'b0;
         end
         @(negedge clk);
      end
   endtask

   // Only destinations 2 and 5 ready: the pointer must skip the others.
   task automatic test_skipping();
      logic [3:0] words [3];
      logic [2:0] sels  [3];
      words = '{4'hA, 4'hB, 4'hC};
      sels  = '{3'd2, 3'd5, 3'd2};
      apply_reset();
      bus.dst_ready = 8'b0010_0100;
      for (int k = 0; k <= 5; k++) begin
         if (k >= 2 && k <= 4) begin
            tests_run++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== words[k-2] || bus.out_sel !== sels[k-2]) begin
               tests_failed++;
               $display("[TB] FAIL skip_issue k=%0d: valid=%b data=%h sel=%0d need 1/%h/%0d",
                        k, bus.out_valid, bus.out_data, bus.out_sel, words[k-2], sels[k-2]);
            end
            $display("[TB] skip issue: data=%h sel=%0d", bus.out_data, bus.out_sel);
         end
         if (k == 5) begin
            tests_run++;
            if (bus.out_valid !== 1'b0) begin
               tests_failed++;
               $display("[TB] FAIL skip_end: valid=%b need 0", bus.out_valid);
            end
         end
         if (k <= 2) begin
            bus.in_valid = 1'b1;
            bus.in_data  = words[k];
         end else begin
            bus.in_valid = 1'b0;
         end
         @(negedge clk);
      end
   endtask

   // Fill with no destination ready, then drain through destination 3.
   task automatic test_backpressure();
      logic [3:0] words [5];
      words = '{4'h3, 4'h7, 4'hE, 4'h1, 4'h9};
      apply_reset();
      bus.dst_ready = 8'h00;
      for (int k = 0; k <= 10; k++) begin
         if (k == 4 || k == 5) begin
            tests_run++;
            if (bus.fifo_count !== 3'd4 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
               tests_failed++;
               $display("[TB] FAIL bp_full k=%0d: count=%0d in_ready=%b valid=%b need 4/0/0",
                        k, bus.fifo_count, bus.in_ready, bus.out_valid);
            end
         end
         if (k >= 6 && k <= 9) begin
            tests_run++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== words[k-6] || bus.out_sel !== 3'd3) begin
               tests_failed++;
               $display("[TB] FAIL bp_drain k=%0d: valid=%b data=%h sel=%0d need 1/%h/3",
                        k, bus.out_valid, bus.out_data, bus.out_sel, words[k-6]);
            end
            $display("[TB] bp drain: data=%h sel=%0d count=%0d", bus.out_data, bus.out_sel, bus.fifo_count);
         end
         if (k == 6) begin
            tests_run++;
            if (bus.fifo_count !== 3'd3 || bus.in_ready !== 1'b1) begin
               tests_failed++;
               $display("[TB] FAIL bp_count_after_load: count=%0d in_ready=%b need 3/1", bus.fifo_count, bus.in_ready);
            end
         end
         if (k == 10) begin
            tests_run++;
            if (bus.out_valid !== 1'b0 || bus.fifo_count !== 3'd0 || bus.out_data !== 4'h0) begin
               tests_failed++;
               $display("[TB] FAIL bp_empty: valid=%b count=%0d data=%h need 0/0/0",
                        bus.out_valid, bus.fifo_count, bus.out_data);
            end
         end
         if (k <= 4) begin
            bus.in_valid = 1'b1;
            bus.in_data  = words[k];
         end else begin
            bus.in_valid = 1'b0;
         end
         if (k == 5) bus.dst_ready = 8'h08;
         @(negedge clk);
      end
   endtask

   // Held word must not move while its destination is stalled.
   task automatic test_hold_stable();
      apply_reset();
      bus.dst_ready = 8'h40;
      for (int k = 0; k <= 7; k++) begin
         if (k == 2 || k == 3 || k == 4 || k == 5) begin
            tests_run++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 4'hD || bus.out_sel !== 3'd6) begin
               tests_failed++;
               $display("[TB] FAIL hold_stable k=%0d: valid=%b data=%h sel=%0d need 1/d/6",
                        k, bus.out_valid, bus.out_data, bus.out_sel);
            end
            $display("[TB] hold: data=%h sel=%0d", bus.out_data, bus.out_sel);
         end
         if (k == 6) begin
            tests_run++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 4'h5 || bus.out_sel !== 3'd7) begin
               tests_failed++;
               $display("[TB] FAIL hold_rr_next: valid=%b data=%h sel=%0d need 1/5/7",
                        bus.out_valid, bus.out_data, bus.out_sel);
            end
            $display("[TB] after hold: data=%h sel=%0d", bus.out_data, bus.out_sel);
         end
         if (k == 7) begin
            tests_run++;
            if (bus.out_valid !== 1'b0 || bus.out_data !== 4'h0) begin
               tests_failed++;
               $display("[TB] FAIL hold_idle: valid=%b data=%h need 0/0", bus.out_valid, bus.out_data);
            end
         end
         bus.in_valid = (k <= 1);
         bus.in_data  = (k == 0) ? 4'hD : 4'h5;
         if (k == 2) bus.dst_ready = 8'h00;
         if (k == 5) bus.dst_ready = 8'hFF;
         @(negedge clk);
      end
   endtask

   // Reset dropped between edges must clear everything without a clock.
   task automatic test_async_reset();
      apply_reset();
      bus.dst_ready = 8'h00;
      for (int k = 0; k <= 5; k++) begin
         if (k == 5) begin
            tests_run++;
            if (bus.out_valid !== 1'b1 || bus.fifo_count !== 3'd3 || bus.out_data !== 4'h2) begin
               tests_failed++;
               $display("[TB] FAIL areset_setup: valid=%b count=%0d data=%h need 1/3/2",
                        bus.out_valid, bus.fifo_count, bus.out_data);
            end
         end
         bus.in_valid = (k <= 3);
         bus.in_data  = 4'(k + 2);
         bus.dst_ready = (k == 4) ? 8'h01 : 8'h00;
         if (k < 5) @(negedge clk);
      end
      #1 rst_n = 1'b0;
      #1;
      tests_run++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== 4'h0 || bus.out_sel !== 3'd0) begin
         tests_failed++;
         $display("[TB] FAIL areset_out: valid=%b data=%h sel=%0d need 0/0/0",
                  bus.out_valid, bus.out_data, bus.out_sel);
      end
      tests_run++;
      if (bus.fifo_count !== 3'd0 || bus.in_ready !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL areset_fifo: count=%0d in_ready=%b need 0/1", bus.fifo_count, bus.in_ready);
      end
      $display("[TB] async reset: valid=%b count=%0d", bus.out_valid, bus.fifo_count);
      @(negedge clk);
      rst_n = 1'b1;
      bus.dst_ready = 8'hFF;
      repeat (3) @(negedge clk);
      tests_run++;
      if (bus.out_valid !== 1'b0 || bus.fifo_count !== 3'd0) begin
         tests_failed++;
         $display("[TB] FAIL areset_lost: valid=%b count=%0d need 0/0", bus.out_valid, bus.fifo_count);
      end
   endtask

   initial begin
      tests_run     = 0;
      tests_failed  = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = 4'h0;
      bus.dst_ready = 8'h00;
      test_reset();
      test_round_robin();
      test_skipping();
      test_backpressure();
      test_hold_stable();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
